// File: rtl/id_loader.sv
// Writer side of the day02 box-ID memory: packs newline-terminated lines of
// ID_LEN lowercase letters from a byte stream into words at consecutive addresses.
module id_loader #(
    parameter int unsigned ID_LEN = 26,
    parameter int unsigned DEPTH  = 250,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [ID_LEN*8-1:0]   wr_data,
    output logic [ADDR_W-1:0]     count,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned DATA_W = ID_LEN * 8;
    localparam int unsigned CW     = $clog2(ID_LEN + 1);
    localparam logic [CW-1:0]     C_FULL = CW'(ID_LEN);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_A   = 8'h61;
    localparam logic [7:0] CH_Z   = 8'h7A;

    typedef enum logic [1:0] {ACCUM, DISCARD, WRITE, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      c;
    logic               eos;
    logic [DATA_W-1:0]  pack;

    logic xfer_c;
    logic letter_c;

    assign xfer_c   = in_valid && in_ready;
    assign letter_c = (in_data >= CH_A) && (in_data <= CH_Z);

    // The packing and count registers are themselves the write port.
    assign wr_data = pack;
    assign wr_addr = count;

    // Line parser; in_ready tracks whether the next state accepts bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            c        <= '0;
            eos      <= 1'b0;
            pack     <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            in_ready <= (state == ACCUM) || (state == DISCARD);
            case (state)
                ACCUM: begin
                    if (xfer_c) begin
                        if (letter_c) begin
                            if (c != C_FULL) begin
                                for (int k = 0; k < int'(ID_LEN); k++) begin
                                    if (c == CW'(k)) pack[8*k +: 8] <= in_data;
                                end
                                c <= c + CW'(1);
                            end else begin
                                err   <= 1'b1;
                                state <= DISCARD;
                            end
                        end else if (in_data == CH_CR) begin
                            state <= ACCUM;
                        end else if (in_data == CH_LF) begin
                            if (c == C_FULL) begin
                                state    <= WRITE;
                                wr_en    <= 1'b1;
                                in_ready <= 1'b0;
                            end else if (c != '0) begin
                                err <= 1'b1;
                                c   <= '0;
                            end
                        end else if (in_data == CH_NUL) begin
                            in_ready <= 1'b0;
                            if (c == C_FULL) begin
                                state <= WRITE;
                                wr_en <= 1'b1;
                                eos   <= 1'b1;
                            end else begin
                                if (c != '0) err <= 1'b1;
                                c     <= '0;
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            err   <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (xfer_c) begin
                        if (in_data == CH_LF) begin
                            c     <= '0;
                            state <= ACCUM;
                        end else if (in_data == CH_NUL) begin
                            c        <= '0;
                            state    <= DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    count <= count + ADDR_W'(1);
                    c     <= '0;
                    if ((count == LAST) || eos) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                end
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_loader.sv
// Directed bench for id_loader: expected memory writes are queued as lines are
// sent and checked against each wr_en strobe.
module tb_id_loader;

    localparam int unsigned ID_LEN = 26;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DW     = ID_LEN * 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic [ADDR_W-1:0] count;
    logic              done;
    logic              err;

    id_loader #(.ID_LEN(ID_LEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } exp_t;

    exp_t  sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    nwr         = 0;
    string alpha  = "abcdefghijklmnopqrstuvwxyz";
    string ralpha = "zyxwvutsrqponmlkjihgfedcba";
    string mixed  = "qwertyuiopasdfghjklzxcvbnm";

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_str(input string s);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < int'(ID_LEN); k++) w[8*k +: 8] = s[k];
        return w;
    endfunction

    task automatic push_exp(input int addr, input string s);
        exp_t e;
        e.addr = ADDR_W'(addr);
        e.data = pack_str(s);
        sb.push_back(e);
    endtask

    // Present one byte and hold it until it transfers (bounded).
    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 256'(in_ready), 256'(1));
        else @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic line(input string s);
        send_str(s);
        send(8'h0A);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_wr_en",    256'(wr_en),    256'(0));
        chk("rst_wr_addr",  256'(wr_addr),  256'(0));
        chk("rst_wr_data",  256'(wr_data),  256'(0));
        chk("rst_count",    256'(count),    256'(0));
        chk("rst_done",     256'(done),     256'(0));
        chk("rst_err",      256'(err),      256'(0));
        sb.delete();
        nwr   = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 256'(in_ready), 256'(1));
    endtask

    task automatic finish_test(input string tag, input int exp_cnt, input logic exp_err);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_count"}, 256'(count), 256'(exp_cnt));
        chk({tag, "_err"},   256'(err),   256'(exp_err));
        chk({tag, "_done"},  256'(done),  256'(1));
        chk({tag, "_nwr"},   256'(nwr),   256'(exp_cnt));
        chk({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && wr_en) begin
            nwr++;
            if (sb.size() == 0) begin
                chk("unexpected_wr", 256'(wr_en), 256'(0));
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 256'(wr_addr), 256'(e.addr));
                chk("wr_data", 256'(wr_data), 256'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Two full lines then end-of-stream.
        do_reset();
        push_exp(0, alpha);
        line(alpha);
        push_exp(1, ralpha);
        line(ralpha);
        send(8'h00);
        finish_test("t1", 2, 1'b0);
        chk("t1_last_byte0", 256'(wr_data[7:0]), 256'(8'h7A));

        // Short line is dropped with err, next line lands at 0.
        do_reset();
        line(alpha.substr(0, 24));
        repeat (2) @(negedge clk);
        chk("t2_err_short", 256'(err), 256'(1));
        chk("t2_count_short", 256'(count), 256'(0));
        push_exp(0, mixed);
        line(mixed);
        send(8'h00);
        finish_test("t2", 1, 1'b1);

        // Overlength line discarded, bad character line discarded.
        do_reset();
        line({alpha, "a"});
        line({"abc", "!", "def"});
        push_exp(0, ralpha);
        line(ralpha);
        send(8'h00);
        finish_test("t3", 1, 1'b1);

        // CRLF endings and blank lines; last ID ended by NUL after CR.
        do_reset();
        send_str(alpha); send(8'h0D); send(8'h0A);
        push_exp(0, alpha);
        send(8'h0D); send(8'h0A);
        send(8'h0A);
        push_exp(1, mixed);
        send_str(mixed); send(8'h0D); send(8'h0A);
        send(8'h0A);
        push_exp(2, ralpha);
        send_str(ralpha); send(8'h0D); send(8'h00);
        finish_test("t4", 3, 1'b0);

        // Capacity: DEPTH writes, then no further bytes accepted.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_exp(i, (i % 2 == 0) ? alpha : ralpha);
            line((i % 2 == 0) ? alpha : ralpha);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h61;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_ready_low", 256'(in_ready), 256'(0));
        end
        finish_test("t5", 4, 1'b0);

        // Reset mid-line aborts; restart writes from address 0.
        do_reset();
        push_exp(0, alpha);
        line(alpha);
        send_str(ralpha.substr(0, 9));
        do_reset();
        chk("t6_nwr_after_rst", 256'(nwr), 256'(0));
        push_exp(0, mixed);
        line(mixed);
        send(8'h00);
        finish_test("t6", 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
